// File: rtl/multi_operand_sum_pkg.sv
// Shared types and constants for the multi-operand sum sequencer.
// Optional feature macro: MULTI_OPERAND_SUM_SAT_EN (saturating result).
package multi_operand_sum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_OPS = 4;

  // Accumulator wide enough that the exact sum of num_ops operands never overflows.
  function automatic int acc_w(input int width, input int num_ops);
    return width + $clog2(num_ops);
  endfunction

  // Largest representable signed value at the given width.
  function automatic longint sum_max(input int width);
    return (longint'(1) << (width - 1)) - longint'(1);
  endfunction

  // Smallest representable signed value at the given width.
  function automatic longint sum_min(input int width);
    return -(longint'(1) << (width - 1));
  endfunction

endpackage

// File: rtl/sum_seq_alu.sv
// Shared adder stage: acc + sign-extended operand, then narrowing of the
// result to WIDTH with overflow detection. When MULTI_OPERAND_SUM_SAT_EN is
// defined the narrowed value clamps to the signed limits on overflow.
module sum_seq_alu
  import multi_operand_sum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = acc_w(DEF_WIDTH, DEF_NUM_OPS)
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [WIDTH-1:0] i_operand,
  output logic [ACC_W-1:0] o_sum,
  output logic [WIDTH-1:0] o_narrow,
  output logic             o_ovf
);

  logic [ACC_W-1:0]   w_ext;
  logic [ACC_W-WIDTH:0] w_hi;

  assign w_ext = {{(ACC_W-WIDTH){i_operand[WIDTH-1]}}, i_operand};
  assign o_sum = i_acc + w_ext;

  // The sum fits in WIDTH signed bits only if every bit above the WIDTH sign
  // bit equals it; any disagreement means the exact value is out of range.
  assign w_hi  = o_sum[ACC_W-1:WIDTH-1];
  assign o_ovf = !((&w_hi) || !(|w_hi));

`ifdef MULTI_OPERAND_SUM_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sum_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sum_min(WIDTH));

  // Clamp toward the side indicated by the accumulator sign.
  always_comb begin
    o_narrow = o_sum[WIDTH-1:0];
    if (o_ovf) begin
      o_narrow = o_sum[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign o_narrow = o_sum[WIDTH-1:0];
`endif

endmodule

// File: rtl/multi_operand_sum_sequencer.sv
// Time-multiplexed signed sum of NUM_OPS operands through one shared adder.
// Accepts an operand vector in IDLE, adds one operand per clock in ACCUM and
// presents the registered result in DONE until the consumer takes it.
// Optional feature macro: MULTI_OPERAND_SUM_SAT_EN (saturating out_sum).
module multi_operand_sum_sequencer
  import multi_operand_sum_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_OPS = DEF_NUM_OPS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] in_ops,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_ovf,
  output logic                     busy
);

  localparam int ACC_W = acc_w(WIDTH, NUM_OPS);
  localparam int IDX_W = $clog2(NUM_OPS);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [NUM_OPS*WIDTH-1:0] r_ops;
  logic [ACC_W-1:0]         r_acc;
  logic [IDX_W-1:0]         r_idx;
  logic [WIDTH-1:0]         r_out_sum;
  logic                     r_out_ovf;

  logic [WIDTH-1:0]         w_op_arr [NUM_OPS];
  logic [WIDTH-1:0]         w_op_sel;
  logic [ACC_W-1:0]         w_sum;
  logic [WIDTH-1:0]         w_narrow;
  logic                     w_ovf;
  logic                     w_last;

  // Unpack the captured operand vector; operand 0 sits in the low bits.
  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_unpack
    assign w_op_arr[gi] = r_ops[gi*WIDTH +: WIDTH];
  end

  assign w_op_sel = w_op_arr[r_idx];
  assign w_last   = (r_idx == IDX_W'(NUM_OPS - 1));

  sum_seq_alu #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_alu (
    .i_acc     (r_acc),
    .i_operand (w_op_sel),
    .o_sum     (w_sum),
    .o_narrow  (w_narrow),
    .o_ovf     (w_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; DONE always returns to IDLE before a new vector is taken.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = ACCUM;
      ACCUM:   if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, one accumulate per cycle, result latch on the
  // final add so out_sum/out_ovf stay stable for the whole DONE period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ops     <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_out_sum <= '0;
      r_out_ovf <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_ops <= in_ops;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        ACCUM: begin
          r_acc <= w_sum;
          if (w_last) begin
            r_idx     <= '0;
            r_out_sum <= w_narrow;
            r_out_ovf <= w_ovf;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum = r_out_sum;
  assign out_ovf = r_out_ovf;

endmodule

// File: tb/tb_multi_operand_sum_sequencer.sv
// Directed self-checking bench for multi_operand_sum_sequencer (WIDTH=8, NUM_OPS=4).
// Expected sums are hand-computed; MULTI_OPERAND_SUM_SAT_EN selects the
// saturated expectations.
module tb_multi_operand_sum_sequencer;

  localparam int WIDTH   = 8;
  localparam int NUM_OPS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_ops = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_sum;
  logic        out_ovf;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  multi_operand_sum_sequencer #(
    .WIDTH   (WIDTH),
    .NUM_OPS (NUM_OPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ops    (in_ops),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MULTI_OPERAND_SUM_SAT_EN
  localparam logic [7:0] EXP_T1   = 8'h80;
  localparam logic [7:0] EXP_T4   = 8'h7F;
  localparam logic [7:0] EXP_BB1  = 8'h80;
  localparam logic [7:0] EXP_BP   = 8'h7F;
`else
  localparam logic [7:0] EXP_T1   = 8'h06;
  localparam logic [7:0] EXP_T4   = 8'hFC;
  localparam logic [7:0] EXP_BB1  = 8'h00;
  localparam logic [7:0] EXP_BP   = 8'h80;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction with out_ready high: accept, check latency, result and return to IDLE.
  task automatic run_txn(input string tag, input logic [31:0] ops,
                         input logic [7:0] exp_sum, input logic exp_ovf);
    int early;
    early = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_ops    = ops;
    out_ready = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);                 // acceptance edge (cycle 0)
    @(negedge clk);
    in_valid = 1'b0;
    in_ops   = 32'hDEADBEEF;        // operands must have been captured already
    for (int k = 1; k < NUM_OPS; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) early++;
    end
    chk({tag, "_early_valid"}, early, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, exp_sum);
    chk({tag, "_ovf"}, out_ovf, exp_ovf);
    @(posedge clk);                 // result handshake
    @(negedge clk);
    chk({tag, "_idle_ready"}, in_ready, 1);
    chk({tag, "_valid_drop"}, out_valid, 0);
    $display("txn %s ops=0x%08h sum=0x%02h ovf=%0b", tag, ops, out_sum, out_ovf);
  endtask

  initial begin
    int t_wait;
    int acc_idx;
    int res_idx;
    int acc_cyc [3];
    logic [31:0] bb_vec [3];
    logic [7:0]  bb_sum [3];
    logic        bb_ovf [3];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_ovf", out_ovf, 0);
    rst = 1'b0;

    // Basic vectors
    run_txn("neg250",   32'hE0D5BF92, EXP_T1, 1'b1);
    run_txn("neg250_r", 32'h92E0BFD5, EXP_T1, 1'b1);
    run_txn("small",    32'h04030201, 8'h0A,  1'b0);
    run_txn("pos508",   32'h7F7F7F7F, EXP_T4, 1'b1);

    // Reset during ACCUM
    @(negedge clk);
    in_valid = 1'b1;
    in_ops   = 32'h10101010;
    @(posedge clk);                 // accept (cycle 0)
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);                 // cycle 1
    @(posedge clk);                 // cycle 2
    @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_sum", out_sum, 0);
    chk("mid_rst_ovf", out_ovf, 0);
    $display("txn mid_reset busy=%0b in_ready=%0b", busy, in_ready);
    run_txn("ones", 32'h01010101, 8'h04, 1'b0);

    // Backpressure: result held, in_ready low, new vector not captured
    @(negedge clk);
    in_valid  = 1'b1;
    in_ops    = 32'h0000017F;       // 127 + 1 = 128
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_ops = 32'h55555555;
    t_wait = 0;
    while (!out_valid && t_wait < 20) begin
      @(posedge clk);
      @(negedge clk);
      t_wait++;
    end
    chk("bp_reach_done", out_valid, 1);
    for (int k = 0; k < 6; k++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_sum_stable", out_sum, EXP_BP);
      chk("bp_ovf_stable", out_ovf, 1);
      in_ops = $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    in_ops    = 32'h05050505;       // pending vector, sum 20
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    @(posedge clk);                 // pending vector accepted here
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_pending_busy", busy, 1);
    t_wait = 0;
    while (!out_valid && t_wait < 20) begin
      @(posedge clk);
      @(negedge clk);
      t_wait++;
    end
    chk("bp_pending_valid", out_valid, 1);
    chk("bp_pending_sum", out_sum, 8'h14);
    chk("bp_pending_ovf", out_ovf, 0);
    $display("txn backpressure pending sum=0x%02h ovf=%0b", out_sum, out_ovf);
    @(posedge clk);

    // Back-to-back with in_valid held high
    bb_vec[0] = 32'h281E140A; bb_sum[0] = 8'h64;   bb_ovf[0] = 1'b0;  // 100
    bb_vec[1] = 32'h80808080; bb_sum[1] = EXP_BB1; bb_ovf[1] = 1'b1;  // -512
    bb_vec[2] = 32'h01FFFFFF; bb_sum[2] = 8'hFE;   bb_ovf[2] = 1'b0;  // -2
    acc_idx = 0;
    res_idx = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (out_valid && res_idx < 3) begin
        chk("bb_sum", out_sum, bb_sum[res_idx]);
        chk("bb_ovf", out_ovf, bb_ovf[res_idx]);
        $display("txn bb%0d sum=0x%02h ovf=%0b", res_idx, out_sum, out_ovf);
        res_idx++;
      end
      if (in_ready) begin
        if (acc_idx < 3) begin
          in_ops           = bb_vec[acc_idx];
          acc_cyc[acc_idx] = cyc;
          acc_idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bb_accepts", acc_idx, 3);
    chk("bb_results", res_idx, 3);
    if (acc_idx == 3) begin
      chk("bb_gap01", acc_cyc[1] - acc_cyc[0], NUM_OPS + 2);
      chk("bb_gap12", acc_cyc[2] - acc_cyc[1], NUM_OPS + 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
